// File: rtl/i_cache_mem_responder.sv
// i_cache_mem_responder: memory-side responder for the instruction cache.
// Fixed-latency reads, with a posted write buffer in front of the array.
module i_cache_mem_responder #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADD_WIDTH    = 12,
  parameter int DEPTH        = 4096,
  parameter int READ_LATENCY = 2,
  parameter int WBUF_DEPTH   = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  m_ren,
  input  logic [ADD_WIDTH-1:0]  m_rd_address,
  input  logic                  m_wen,
  input  logic [ADD_WIDTH-1:0]  m_wr_address,
  input  logic [DATA_WIDTH-1:0] m_data_out,
  output logic [DATA_WIDTH-1:0] m_data_in,
  output logic                  m_rd_valid,
  output logic                  m_busy,
  output logic                  wbuf_full,
  output logic                  wr_overflow
);

  localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CW = $clog2(WBUF_DEPTH + 1);
  localparam int LW = 4;
  localparam logic [LW-1:0] LAST = LW'(READ_LATENCY - 2);
  localparam logic [CW-1:0] FULL = CW'(WBUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RESP
  } state_t;

  state_t                state;
  logic [LW-1:0]         lat_cnt;
  logic [DATA_WIDTH-1:0] rd_data;

  logic [DATA_WIDTH-1:0] mem     [DEPTH];
  logic [ADD_WIDTH-1:0]  wb_addr [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] wb_data [WBUF_DEPTH];

  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;

  logic                  accept;
  logic                  pop;
  logic                  push;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [DATA_WIDTH-1:0] resolved;
  logic [PW-1:0]         idx;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    if (int'(p) == WBUF_DEPTH - 1) return '0;
    return p + PW'(1);
  endfunction

  // A drain never shares an edge with an accept, so reads see a
  // stable buffer and the array port is never contended.
  assign accept    = (state == IDLE) && m_ren;
  assign pop       = (count != '0) && !accept;
  assign push      = m_wen && ((count != FULL) || pop);
  assign count_nxt = count + CW'(push) - CW'(pop);

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = rd_ptr;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (i < int'(count) && wb_addr[idx] == m_rd_address) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[idx];
      end
      idx = nxt(idx);
    end
  end

  // Same-cycle victim first, then buffered writes, then the array.
  always_comb begin
    resolved = mem[m_rd_address];
    if (m_wen && m_wr_address == m_rd_address)
      resolved = m_data_out;
    else if (fwd_hit)
      resolved = fwd_data;
  end

  // Read FSM: accept, wait out the latency, pulse the response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      rd_data    <= '0;
      m_data_in  <= '0;
      m_rd_valid <= 1'b0;
      m_busy     <= 1'b0;
    end else begin
      m_rd_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (m_ren) begin
            rd_data <= resolved;
            lat_cnt <= '0;
            m_busy  <= 1'b1;
            if (READ_LATENCY == 1) begin
              state      <= RESP;
              m_rd_valid <= 1'b1;
              m_data_in  <= resolved;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (lat_cnt == LAST) begin
            state      <= RESP;
            m_rd_valid <= 1'b1;
            m_data_in  <= rd_data;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        RESP: begin
          state  <= IDLE;
          m_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write buffer bookkeeping: pointers, occupancy and flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      wbuf_full   <= 1'b0;
      wr_overflow <= 1'b0;
    end else begin
      if (pop) rd_ptr <= nxt(rd_ptr);
      if (push) wr_ptr <= nxt(wr_ptr);
      if (m_wen && !push) wr_overflow <= 1'b1;
      count     <= count_nxt;
      wbuf_full <= (count_nxt == FULL);
    end
  end

  // Buffer payload; slots past the count are never looked at.
  always_ff @(posedge clock) begin
    if (push) begin
      wb_addr[wr_ptr] <= m_wr_address;
      wb_data[wr_ptr] <= m_data_out;
    end
  end

  // Storage array keeps its contents across reset.
  always_ff @(posedge clock) begin
    if (pop) mem[wb_addr[rd_ptr]] <= wb_data[rd_ptr];
  end

endmodule

// File: tb/tb_i_cache_mem_responder.sv
// tb_i_cache_mem_responder: directed and random checks of the responder
// against a queue-based model of the memory and write buffer.
module tb_i_cache_mem_responder;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int ND = 4096;
  localparam int RL = 2;
  localparam int WD = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          m_ren = 1'b0;
  logic [AW-1:0] m_rd_address = '0;
  logic          m_wen = 1'b0;
  logic [AW-1:0] m_wr_address = '0;
  logic [DW-1:0] m_data_out = '0;
  logic [DW-1:0] m_data_in;
  logic          m_rd_valid;
  logic          m_busy;
  logic          wbuf_full;
  logic          wr_overflow;

  always #5 clock = ~clock;

  i_cache_mem_responder #(
    .DATA_WIDTH(DW),
    .ADD_WIDTH(AW),
    .DEPTH(ND),
    .READ_LATENCY(RL),
    .WBUF_DEPTH(WD)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .m_ren(m_ren),
    .m_rd_address(m_rd_address),
    .m_wen(m_wen),
    .m_wr_address(m_wr_address),
    .m_data_out(m_data_out),
    .m_data_in(m_data_in),
    .m_rd_valid(m_rd_valid),
    .m_busy(m_busy),
    .wbuf_full(wbuf_full),
    .wr_overflow(wr_overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           q[$];
  logic [DW-1:0] mem_m [int];
  bit            pend = 0;
  int            cyc = 0;
  int            resp_cyc = 0;
  logic [DW-1:0] pend_d = '0;
  logic [DW-1:0] e_data = '0;
  bit            e_ovf = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pend   = 0;
    e_data = '0;
    e_ovf  = 0;
  endtask

  task automatic step();
    bit            idle;
    bit            acc;
    bit            pop;
    bit            hit;
    logic [DW-1:0] rd;
    wr_t           e;
    idle = !pend || (cyc >= resp_cyc + 1);
    @(posedge clock);
    cyc++;
    if (reset_n) begin
      acc = m_ren && idle;
      if (acc) begin
        rd = 'x;
        if (m_wen && m_wr_address == m_rd_address) begin
          rd = m_data_out;
        end else begin
          hit = 0;
          for (int i = q.size() - 1; i >= 0; i--)
            if (!hit && q[i].a == m_rd_address) begin
              hit = 1;
              rd  = q[i].d;
            end
          if (!hit && mem_m.exists(int'(m_rd_address)))
            rd = mem_m[int'(m_rd_address)];
        end
        pend     = 1;
        pend_d   = rd;
        resp_cyc = cyc + RL - 1;
      end
      pop = (q.size() != 0) && !acc;
      if (pop) begin
        e = q.pop_front();
        mem_m[int'(e.a)] = e.d;
      end
      if (m_wen) begin
        if (q.size() == WD) begin
          e_ovf = 1;
        end else begin
          e.a = m_wr_address;
          e.d = m_data_out;
          q.push_back(e);
        end
      end
      if (pend && cyc == resp_cyc) e_data = pend_d;
    end
    #1;
    check("rd_valid", 32'(m_rd_valid), 32'(pend && cyc == resp_cyc));
    check("busy", 32'(m_busy), 32'(pend && cyc <= resp_cyc));
    check("wbuf_full", 32'(wbuf_full), 32'(q.size() == WD));
    check("wr_overflow", 32'(wr_overflow), 32'(e_ovf));
    check("data_in", m_data_in, e_data);
  endtask

  task automatic read_word(input logic [AW-1:0] a,
                           output logic [DW-1:0] d);
    int t;
    int lat;
    m_ren = 1'b1;
    m_rd_address = a;
    t = 0;
    while (pend && cyc < resp_cyc + 1 && t < 20) begin
      step();
      t++;
    end
    step();
    m_ren = 1'b0;
    m_wen = 1'b0;
    lat = 0;
    while (m_rd_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check("rd_latency", 32'(lat), 32'(RL - 1));
    d = m_data_in;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [AW-1:0] pool [9] = '{12'h010, 12'h020, 12'h0DD, 12'h0F2,
                              12'h3F2, 12'h100, 12'h101, 12'h102, 12'h0A5};
  logic [AW-1:0] t4a [7] = '{12'h101, 12'h102, 12'h020, 12'h020,
                             12'h020, 12'h020, 12'h0DD};
  logic [DW-1:0] t4d [7] = '{32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3,
                             32'hA4A4A4A4, 32'hA5A5A5A5, 32'hA6A6A6A6,
                             32'hBADBADBA};

  initial begin
    logic [DW-1:0] d;
    int pulses[$];
    int npulse;

    // Reset state
    #1;
    check("reset_valid", 32'(m_rd_valid), 32'd0);
    check("reset_busy", 32'(m_busy), 32'd0);
    step();
    step();
    reset_n = 1'b1;

    // Prefill every address the bench will read
    for (int i = 0; i < 9; i++) begin
      m_wen = 1'b1;
      m_wr_address = pool[i];
      if (pool[i] == 12'h0F2) m_data_out = 32'h0F20F20F;
      else if (pool[i] == 12'h0DD) m_data_out = 32'h0D0D0D0D;
      else m_data_out = $urandom;
      step();
    end
    m_wen = 1'b0;
    repeat (3) step();

    // Test 1: write, drain, read back
    m_wen = 1'b1;
    m_wr_address = 12'h0A5;
    m_data_out = 32'hDEADBEEF;
    step();
    m_wen = 1'b0;
    repeat (2) step();
    read_word(12'h0A5, d);
    check("t1_data", d, 32'hDEADBEEF);

    // Test 2: forwarding of the younger buffered write
    m_ren = 1'b1;
    m_rd_address = 12'h100;
    step();
    m_ren = 1'b0;
    m_wen = 1'b1;
    m_wr_address = 12'h010;
    m_data_out = 32'h11111111;
    step();
    m_data_out = 32'h22222222;
    step();
    m_wen = 1'b0;
    m_ren = 1'b1;
    m_rd_address = 12'h010;
    step();
    m_ren = 1'b0;
    step();
    check("t2_fwd_valid", 32'(m_rd_valid), 32'd1);
    check("t2_fwd_data", m_data_in, 32'h22222222);
    repeat (3) step();
    read_word(12'h010, d);
    check("t2_array", d, 32'h22222222);

    // Test 3: victim write and fill read on the same edge
    m_wen = 1'b1;
    m_wr_address = 12'h3F2;
    m_data_out = 32'hCAFEF00D;
    read_word(12'h0F2, d);
    check("t3_prior", d, 32'h0F20F20F);
    repeat (2) step();
    read_word(12'h3F2, d);
    check("t3_victim", d, 32'hCAFEF00D);

    // Tests 4 and 5: level read blocking drain, overflow, spacing
    m_ren = 1'b1;
    m_rd_address = 12'h020;
    for (int i = 0; i < 15; i++) begin
      if (i < 7) begin
        m_wen = 1'b1;
        m_wr_address = t4a[i];
        m_data_out = t4d[i];
      end else begin
        m_wen = 1'b0;
      end
      step();
      if (m_rd_valid === 1'b1) pulses.push_back(i);
      if (i == 3) check("t4_full_2nd", 32'(wbuf_full), 32'd1);
      if (i == 6) check("t4_ovf_3rd", 32'(wr_overflow), 32'd1);
      if (i == 7) check("t4_youngest", m_data_in, 32'hA6A6A6A6);
    end
    m_ren = 1'b0;
    check("t5_pulses", 32'(pulses.size()), 32'd5);
    for (int i = 1; i < pulses.size(); i++)
      check("t5_spacing", 32'(pulses[i] - pulses[i-1]), 32'(RL + 1));
    repeat (3) step();
    read_word(12'h0DD, d);
    check("t4_dropped", d, 32'h0D0D0D0D);
    read_word(12'h020, d);
    check("t4_array", d, 32'hA6A6A6A6);
    check("t4_ovf_sticky", 32'(wr_overflow), 32'd1);

    // Test 6: asynchronous reset during RD_WAIT
    m_ren = 1'b1;
    m_rd_address = 12'h101;
    step();
    m_ren = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("t6_valid", 32'(m_rd_valid), 32'd0);
    check("t6_busy", 32'(m_busy), 32'd0);
    check("t6_full", 32'(wbuf_full), 32'd0);
    check("t6_ovf", 32'(wr_overflow), 32'd0);
    check("t6_data", m_data_in, 32'd0);
    step();
    step();
    reset_n = 1'b1;
    npulse = 0;
    repeat (5) begin
      step();
      if (m_rd_valid === 1'b1) npulse++;
    end
    check("t6_no_resp", 32'(npulse), 32'd0);
    read_word(12'h010, d);
    check("t6_keep_010", d, 32'h22222222);
    read_word(12'h0F2, d);
    check("t6_keep_0f2", d, 32'h0F20F20F);
    read_word(12'h3F2, d);
    check("t6_keep_3f2", d, 32'hCAFEF00D);

    // Random traffic over the prefilled addresses
    for (int i = 0; i < 400; i++) begin
      m_ren = 1'($urandom_range(0, 1));
      m_rd_address = pool[$urandom_range(0, 8)];
      m_wen = ($urandom_range(0, 3) == 0);
      m_wr_address = pool[$urandom_range(0, 8)];
      m_data_out = $urandom;
      step();
    end
    m_ren = 1'b0;
    m_wen = 1'b0;
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
